// File: rtl/ram_sync_param.sv
// Single-port word RAM with registered address and write inputs, and a background clear sweep.
// Define RAM_SYNC_AUTOCLEAR_EN to make reset start a full clear sweep instead of idling.
module ram_sync_param #(
  parameter int                 ADDR_W = 5,
  parameter int                 DATA_W = 4,
  parameter logic [DATA_W-1:0]  FILL   = '0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

`ifdef RAM_SYNC_AUTOCLEAR_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                done_reg, done_next;
  logic [ADDR_W-1:0]   reg_addr;
  logic [DATA_W-1:0]   reg_data;
  logic                reg_wr;
  logic                wr_sample;
  logic                last_word;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign last_word = (cnt_reg == {ADDR_W{1'b1}});

  // A write is only captured in IDLE without a competing clear; anything seen while sweeping is dropped.
  assign wr_sample = write && (state_reg == IDLE) && !clear_req;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        cnt_next = cnt_reg + 1'b1;
        if (last_word) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      reg_wr    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      reg_addr  <= address;
      reg_data  <= data_in;
      reg_wr    <= wr_sample;
    end
  end

  // Memory is never reset; a commit due on the edge entering CLEAR still lands (state is IDLE then).
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[cnt_reg] <= FILL;
    end else if (reg_wr) begin
      mem[reg_addr] <= reg_data;
    end
  end

  assign data_out = mem[reg_addr];
  assign busy     = (state_reg == CLEAR);
  assign done     = done_reg;

endmodule
